// File: rtl/packet_receiver.sv
// packet_receiver
// Playback-side receiver for the 32-bit serial memory packet
// {16-bit address header, 16-bit sample}, shifted in MSB first.
// The block tracks the address sequence the record path produces
// (0x8000, +32 per packet, back to 0x8000 after WRAP_ADDR) and flags
// header and sequence errors alongside each completed sample.
//
// Optional feature: define ERR_COUNT_EN to add a saturating 8-bit count
// of erroneous packets (output err_count).
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   restart     in   sync pulse: abort packet, expected address := 0x8000
//   frame_start in   pulse: the next valid bit is packet bit 31
//   bit_valid   in   serial_in is sampled this cycle
//   serial_in   in   serial data, MSB first
//   bit_count   out  [4:0] index of the next bit expected
//   busy        out  high while shifting a packet
//   addr_out    out  [15:0] header of the last completed packet
//   data_out    out  [15:0] sample of the last completed packet
//   data_valid  out  one-cycle pulse, packet completed
//   hdr_error   out  with data_valid: header bit 15 was 0
//   seq_error   out  with data_valid: header != expected address
//   err_count   out  [7:0] saturating error count (ERR_COUNT_EN only)
module packet_receiver #(
  parameter logic [15:0] WRAP_ADDR = 16'd62720,
  parameter logic [14:0] ADDR_STEP = 15'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        frame_start,
  input  logic        bit_valid,
  input  logic        serial_in,
  output logic [4:0]  bit_count,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        hdr_error,
`ifdef ERR_COUNT_EN
  output logic        seq_error,
  output logic [7:0]  err_count
`else
  output logic        seq_error
`endif
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state;
  // Only the 31 earlier bits are stored; the 32nd bit is folded in
  // directly on the completing edge.
  logic [30:0] shift_reg;
  logic [15:0] expected;
  logic        pending;
  logic        pend_hdr;
  logic        pend_seq;
  logic [31:0] word;

  // Next expected address: 15-bit modulo step, bit 15 forced high.
  function automatic logic [15:0] next_addr(input logic [15:0] cur);
    logic [14:0] low;
    low = cur[14:0] + ADDR_STEP;
    if (cur == WRAP_ADDR) begin
      next_addr = 16'h8000;
    end else begin
      next_addr = {1'b1, low};
    end
  endfunction

  // Completed word as it would look with the current bit shifted in.
  assign word = {shift_reg, serial_in};
  assign busy = (state == SHIFT);

  // Receiver FSM, sequence tracking and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_count  <= 5'd0;
      shift_reg  <= 31'd0;
      expected   <= 16'h8000;
      addr_out   <= 16'h8000;
      data_out   <= 16'h0000;
      pending    <= 1'b0;
      pend_hdr   <= 1'b0;
      pend_seq   <= 1'b0;
      data_valid <= 1'b0;
      hdr_error  <= 1'b0;
      seq_error  <= 1'b0;
`ifdef ERR_COUNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      pending    <= 1'b0;
      data_valid <= 1'b0;
      hdr_error  <= 1'b0;
      seq_error  <= 1'b0;
      if (restart) begin
        // Dropping pending here suppresses a completion still in flight.
        state     <= IDLE;
        bit_count <= 5'd0;
        expected  <= 16'h8000;
`ifdef ERR_COUNT_EN
        err_count <= 8'd0;
`endif
      end else begin
        data_valid <= pending;
        hdr_error  <= pending & pend_hdr;
        seq_error  <= pending & pend_seq;
`ifdef ERR_COUNT_EN
        if (pending && (pend_hdr || pend_seq) && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
`endif
        case (state)
          IDLE: begin
            if (frame_start) begin
              state     <= SHIFT;
              bit_count <= 5'd0;
            end
          end
          SHIFT: begin
            if (frame_start) begin
              // Discard the partial packet and start over.
              bit_count <= 5'd0;
            end else if (bit_valid) begin
              shift_reg <= word[30:0];
              if (bit_count == 5'd31) begin
                addr_out  <= word[31:16];
                data_out  <= word[15:0];
                pending   <= 1'b1;
                pend_hdr  <= ~word[31];
                pend_seq  <= (word[31:16] != expected);
                expected  <= next_addr(expected);
                state     <= IDLE;
                bit_count <= 5'd0;
              end else begin
                bit_count <= bit_count + 5'd1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            bit_count <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        frame_start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        serial_in = 1'b0;
  logic [4:0]  bit_count;
  logic        busy;
  logic [15:0] addr_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        hdr_error;
  logic        seq_error;
`ifdef ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int total = 0;
  int fails = 0;

  // Reference model state: expected address and error count, kept as ints.
  int exp_addr = 32768;
  int err_cnt = 0;

  packet_receiver dut (
    .clk(clk), .reset(reset), .restart(restart), .frame_start(frame_start),
    .bit_valid(bit_valid), .serial_in(serial_in), .bit_count(bit_count),
    .busy(busy), .addr_out(addr_out), .data_out(data_out),
    .data_valid(data_valid), .hdr_error(hdr_error),
`ifdef ERR_COUNT_EN
    .seq_error(seq_error), .err_count(err_count)
`else
    .seq_error(seq_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_next(input int a);
    if (a == 62720) return 32768;
    return a + 32;
  endfunction

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_addr = 32768;
    err_cnt = 0;
    check("restart_busy", {31'd0, busy}, 32'd0);
    check("restart_bitcount", {27'd0, bit_count}, 32'd0);
`ifdef ERR_COUNT_EN
    check("restart_errcnt", {24'd0, err_count}, 32'd0);
`endif
  endtask

  // Start a packet and feed n bits, then leave it unfinished.
  task automatic send_partial(input logic [31:0] w, input int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 31; i > 31 - n; i--) begin
      bit_valid = 1'b1;
      serial_in = w[i];
      tick();
      check("partial_no_dv", {31'd0, data_valid}, 32'd0);
    end
    bit_valid = 1'b0;
  endtask

  // Send one full packet and check completion against the model.
  task automatic send_packet(input logic [31:0] w, input int stall_max, input bit abort_pending);
    logic e_hdr;
    logic e_seq;
    e_hdr = ~w[31];
    e_seq = (int'(w[31:16]) != exp_addr);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 31; i >= 0; i--) begin
      if (stall_max > 0) begin
        repeat ($urandom_range(0, stall_max)) begin
          bit_valid = 1'b0;
          serial_in = $urandom_range(0, 1);
          tick();
          check("stall_no_dv", {31'd0, data_valid}, 32'd0);
        end
      end
      check("bit_count", {27'd0, bit_count}, 32'(31 - i));
      bit_valid = 1'b1;
      serial_in = w[i];
      tick();
      if (i > 0) check("mid_no_dv", {31'd0, data_valid}, 32'd0);
    end
    bit_valid = 1'b0;
    // Completing edge: data registered, data_valid still pending.
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_bitcount", {27'd0, bit_count}, 32'd0);
    check("done_no_dv_yet", {31'd0, data_valid}, 32'd0);
    check("addr_out", {16'd0, addr_out}, {16'd0, w[31:16]});
    check("data_out", {16'd0, data_out}, {16'd0, w[15:0]});
    if (abort_pending) begin
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp_addr = 32768;
      err_cnt = 0;
      check("abort_no_dv", {31'd0, data_valid}, 32'd0);
      check("abort_addr_hold", {16'd0, addr_out}, {16'd0, w[31:16]});
`ifdef ERR_COUNT_EN
      check("abort_errcnt", {24'd0, err_count}, 32'd0);
`endif
    end else begin
      exp_addr = model_next(exp_addr);
      if ((e_hdr || e_seq) && err_cnt < 255) err_cnt++;
      tick();
      check("dv_pulse", {31'd0, data_valid}, 32'd1);
      check("hdr_error", {31'd0, hdr_error}, {31'd0, e_hdr});
      check("seq_error", {31'd0, seq_error}, {31'd0, e_seq});
`ifdef ERR_COUNT_EN
      check("err_count", {24'd0, err_count}, 32'(err_cnt));
`endif
      tick();
      check("dv_drop", {31'd0, data_valid}, 32'd0);
      check("flags_drop", {30'd0, hdr_error, seq_error}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] hdr;
    // Reset state
    tick();
    tick();
    check("rst_bitcount", {27'd0, bit_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {16'd0, addr_out}, 32'h8000);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_flags", {29'd0, data_valid, hdr_error, seq_error}, 32'd0);
    reset = 1'b0;
    tick();

    // bit_valid in IDLE is ignored
    bit_valid = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    check("idle_ignore", {26'd0, busy, bit_count}, 32'd0);

    // First packet, header error packet, then sequence resumes at 0x8040
    send_packet(32'h8000_1234, 0, 1'b0);
    send_packet(32'h0020_ABCD, 0, 1'b0);
    send_packet(32'h8040_0F0F, 2, 1'b0);

    // frame_start after 10 bits discards the partial packet
    do_restart();
    send_partial(32'hFFFF_FFFF, 10);
    send_packet(32'h8000_5555, 0, 1'b0);

    // Full address sequence through the wrap and back to 0x8000
    do_restart();
    for (int k = 0; k < 938; k++) begin
      send_packet({exp_addr[15:0], 16'($urandom)}, 0, 1'b0);
    end
    check("after_wrap_addr", {16'd0, addr_out}, 32'h8000);

    // Restart mid-packet after three good packets
    do_restart();
    for (int k = 0; k < 3; k++) send_packet({exp_addr[15:0], 16'($urandom)}, 1, 1'b0);
    send_partial({exp_addr[15:0], 16'h1111}, 15);
    do_restart();
    send_packet(32'h8000_0001, 0, 1'b0);

    // Restart in the cycle between completion and data_valid
    send_packet({exp_addr[15:0], 16'hBEEF}, 0, 1'b1);
    send_packet(32'h8000_0002, 0, 1'b0);

    // Restart and frame_start together: restart wins
    restart = 1'b1;
    frame_start = 1'b1;
    tick();
    restart = 1'b0;
    frame_start = 1'b0;
    exp_addr = 32768;
    err_cnt = 0;
    check("restart_beats_fs", {31'd0, busy}, 32'd0);

    // Randomised packets: correct or random headers, random stalls
    for (int k = 0; k < 40; k++) begin
      hdr = ($urandom_range(0, 1) == 1) ? exp_addr[15:0] : 16'($urandom);
      send_packet({hdr, 16'($urandom)}, 2, 1'b0);
    end

`ifdef ERR_COUNT_EN
    // Error counter saturation and clear
    do_restart();
    for (int k = 0; k < 300; k++) send_packet({16'h0000, 16'($urandom)}, 0, 1'b0);
    check("errcnt_sat", {24'd0, err_count}, 32'h0000_00FF);
    do_restart();
`endif

    // Asynchronous reset mid-packet
    send_partial(32'h8000_AAAA, 12);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_bitcount", {27'd0, bit_count}, 32'd0);
    check("arst_addr", {16'd0, addr_out}, 32'h8000);
    check("arst_data", {16'd0, data_out}, 32'd0);
    tick();
    reset = 1'b0;
    exp_addr = 32768;
    err_cnt = 0;
    tick();
    send_packet(32'h8000_7777, 0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
